mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requesters onto one single-ported unified memory.
// One access is outstanding at a time, with alternation fairness, a timeout watchdog and halt draining.
`timescale 1ns/1ps

module mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ready,
  input  logic        d_re,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_ready,
  output logic        m_en,
  output logic        m_we,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata,
  input  logic        m_valid,
  input  logic        halt,
  output logic        halted,
  output logic        if_stall,
  output logic        mem_stall,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, HALTED} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t     state;
  logic       fetch_first;
  logic [7:0] cnt;
  logic       dreq;
  logic       fetch_ok;
  logic       ready_pulse;
  logic       wait_done;

  assign dreq        = d_re | d_we;
  assign fetch_ok    = if_req & ~halt;
  assign ready_pulse = if_ready | d_ready;
  assign wait_done   = (cnt + 8'd1) == TMO;

  assign if_stall  = if_req & ~if_ready;
  assign mem_stall = dreq & ~d_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fetch_first <= 1'b0;
      cnt         <= '0;
      err         <= 1'b0;
      halted      <= 1'b0;
      m_en        <= 1'b0;
      m_we        <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      if_rdata    <= '0;
      d_rdata     <= '0;
      if_ready    <= 1'b0;
      d_ready     <= 1'b0;
    end else begin
      m_en     <= 1'b0;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state)
        // Grants wait out the ready cycle, but halting may proceed in it once data is quiet.
        IDLE: begin
          if (!ready_pulse && fetch_ok && (fetch_first || !dreq)) begin
            m_en        <= 1'b1;
            m_we        <= 1'b0;
            m_addr      <= if_addr;
            cnt         <= '0;
            fetch_first <= 1'b0;
            state       <= FETCH;
          end else if (!ready_pulse && dreq) begin
            m_en    <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            cnt     <= '0;
            if (if_req) fetch_first <= 1'b1;
            state   <= DATA;
          end else if (!dreq && halt) begin
            halted <= 1'b1;
            state  <= HALTED;
          end
        end
        FETCH: begin
          if (m_valid) begin
            if_rdata <= m_rdata;
            if_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
            if (wait_done) begin
              err      <= 1'b1;
              if_ready <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        DATA: begin
          if (m_valid) begin
            if (!m_we) d_rdata <= m_rdata;
            d_ready <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
            if (wait_done) begin
              err     <= 1'b1;
              d_ready <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
